// File: rtl/crypt_iter_unroll_if.sv
// Request/response bundle of the iterative DES core: request side drives
// req/dec/k/m, core returns the result block c and the acknowledge.
// Four-phase handshake; no other flow control on this bundle.
`ifndef N_K
`define N_K 64
`endif
`ifndef N_B
`define N_B 64
`endif
`ifndef N_R
`define N_R 16
`endif

interface crypt_iter_unroll_if;
  logic            req;
  logic            dec;
  logic [`N_K-1:0] k;
  logic [`N_B-1:0] m;
  logic [`N_B-1:0] c;
  logic            ack;

  modport master (output req, dec, k, m, input c, ack);
  modport slave  (input req, dec, k, m, output c, ack);
endinterface

// File: rtl/crypt_iter_unroll.sv
// Iterative DES encrypt/decrypt core, UNROLL Feistel rounds per clock.
// Latency: c/ack valid N_R/UNROLL cycles after the request capture edge.
// Backpressure: four-phase req/ack; dropping req mid-run aborts the operation.
`ifndef N_K
`define N_K 64
`endif
`ifndef N_B
`define N_B 64
`endif
`ifndef N_R
`define N_R 16
`endif

// Initial permutation on the block, PC1 on the key.
module pre_processing (
  input  logic [63:0] k,
  input  logic [63:0] m,
  output logic [31:0] r1,
  output logic [31:0] r0,
  output logic [55:0] cd
);
  localparam int PC1_T [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                                10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  logic [63:0] ip;
  // Key parity bits are dropped by PC1.
  wire unused_parity = ^{k[56], k[48], k[40], k[32], k[24], k[16], k[8], k[0]};

  for (genvar i = 0; i < 64; i++) begin : g_ip
    localparam int R   = i / 8;
    localparam int SRC = (R < 4 ? 58 + 2 * R : 49 + 2 * R) - 8 * (i % 8);
    assign ip[63-i] = m[64-SRC];
  end
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    localparam int S = PC1_T[i];
    assign cd[55-i] = k[64-S];
  end
  assign r1 = ip[63:32];
  assign r0 = ip[31:0];
endmodule

// One Feistel round; cd is the already-rotated key state, PC2 applied here.
module round (
  input  logic [63:0] lr,
  input  logic [55:0] cd,
  output logic [63:0] lr_o
);
  localparam int PC2_T [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                                23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                                41,52,31,37,47,55,30,40,51,45,33,48,
                                44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int P_T [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                              2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam logic [0:7][0:63][3:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [31:0] l, r, so, f;
  logic [47:0] kk, e, x;
  // Key-state bits that PC2 never selects.
  wire unused_pc2 = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

  assign l = lr[63:32];
  assign r = lr[31:0];
  for (genvar i = 0; i < 48; i++) begin : g_pc2_e
    localparam int S   = PC2_T[i];
    localparam int SRC = ((4 * (i / 6) + (i % 6) + 31) % 32) + 1;
    assign kk[47-i] = cd[56-S];
    assign e[47-i]  = r[32-SRC];
  end
  assign x = e ^ kk;
  for (genvar s = 0; s < 8; s++) begin : g_sbox
    logic [5:0] six, idx;
    assign six = x[47-6*s -: 6];
    assign idx = {six[5], six[0], six[4:1]};
    assign so[31-4*s -: 4] = SBOX[s][idx];
  end
  for (genvar i = 0; i < 32; i++) begin : g_p
    localparam int S = P_T[i];
    assign f[31-i] = so[32-S];
  end
  assign lr_o = {r, l ^ f};
endmodule

// Final permutation (inverse of the initial permutation).
module post_processing (
  input  logic [63:0] x,
  output logic [63:0] y
);
  for (genvar i = 0; i < 64; i++) begin : g_fp
    localparam int R   = i / 8;
    localparam int SRC = (R < 4 ? 58 + 2 * R : 49 + 2 * R) - 8 * (i % 8);
    assign y[64-SRC] = x[63-i];
  end
endmodule

module crypt_iter_unroll #(
  parameter int UNROLL = 1,
  parameter int N_R    = `N_R
) (
  input logic                clk,
  input logic                rst,
  crypt_iter_unroll_if.slave bus
);
  localparam int CW = $clog2(N_R + 1);
  localparam logic [CW-1:0] STEP = CW'(UNROLL);
  localparam logic [CW-1:0] LAST = CW'(N_R);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("crypt_iter_unroll: UNROLL must be 1, 2, 4, 8 or 16");
  end
  if (N_R % UNROLL != 0) begin : g_bad_nr
    $error("crypt_iter_unroll: N_R must be a multiple of UNROLL");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [63:0]     lr;
  logic [55:0]     cd;
  logic [CW-1:0]   cnt;
  logic            mode;
  logic [63:0]     c_q;
  logic            ack_q;
  logic [31:0]     pre_r1, pre_r0;
  logic [55:0]     pre_cd;
  logic [63:0]     lr_nxt, c_nxt;
  logic [55:0]     cd_nxt;
  logic [CW-1:0]   cnt_nxt;

  // Per-round rotation of one 28-bit key half for round number j.
  function automatic logic [27:0] rot28(input logic [27:0] v, input logic dm, input logic [4:0] j);
    logic one;
    one = (j == 5'd1) || (j == 5'd2) || (j == 5'd9) || (j == 5'd16);
    if (!dm)            rot28 = one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
    else if (j == 5'd1) rot28 = v;
    else                rot28 = one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
  endfunction

  pre_processing u_pre (.k(bus.k), .m(bus.m), .r1(pre_r1), .r0(pre_r0), .cd(pre_cd));

  for (genvar u = 0; u < UNROLL; u++) begin : g_stage
    logic [63:0] lr_i, lr_o;
    logic [55:0] cd_i, cd_o;
    logic [4:0]  j;
    if (u == 0) begin : g_first
      assign lr_i = lr;
      assign cd_i = cd;
    end else begin : g_next
      assign lr_i = g_stage[u-1].lr_o;
      assign cd_i = g_stage[u-1].cd_o;
    end
    assign j    = 5'(cnt) + 5'(u + 1);
    assign cd_o = {rot28(cd_i[55:28], mode, j), rot28(cd_i[27:0], mode, j)};
    round u_round (.lr(lr_i), .cd(cd_o), .lr_o(lr_o));
  end

  assign lr_nxt  = g_stage[UNROLL-1].lr_o;
  assign cd_nxt  = g_stage[UNROLL-1].cd_o;
  assign cnt_nxt = cnt + STEP;

  post_processing u_post (.x({lr_nxt[31:0], lr_nxt[63:32]}), .y(c_nxt));

  // Handshake FSM and round datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lr    <= '0;
      cd    <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      c_q   <= '0;
      ack_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          mode  <= bus.dec;
          lr    <= {pre_r1, pre_r0};
          cd    <= pre_cd;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: if (!bus.req) begin
          state <= IDLE;
        end else begin
          lr  <= lr_nxt;
          cd  <= cd_nxt;
          cnt <= cnt_nxt;
          if (cnt_nxt == LAST) begin
            c_q   <= c_nxt;
            ack_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (!bus.req) begin
          ack_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.c   = c_q;
  assign bus.ack = ack_q;
endmodule

// File: tb/tb_crypt_iter_unroll.sv
// Directed bench for crypt_iter_unroll at UNROLL = 1, 2, 4, 8, 16.
// Known DES vectors, abort, async reset mid-run and handshake hold.
// Inputs driven 1 ns after the rising edge, outputs sampled there too.
`timescale 1ns/1ps
module tb_crypt_iter_unroll;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq [5];
  logic        dec_i;
  logic [63:0] k_i, m_i;
  logic        ack_v [5];
  logic [63:0] c_v [5];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    crypt_iter_unroll_if bus ();
    assign bus.req  = rq[g];
    assign bus.dec  = dec_i;
    assign bus.k    = k_i;
    assign bus.m    = m_i;
    assign ack_v[g] = bus.ack;
    assign c_v[g]   = bus.c;
    crypt_iter_unroll #(.UNROLL(1 << g)) dut (.clk(clk), .rst(rst), .bus(bus));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Raise req with the given operands; returns just after the capture edge
  // with the operands scrambled so late input changes would be visible.
  task automatic start(input int u, input logic d, input logic [63:0] kk, input logic [63:0] mm);
    @(posedge clk); #1;
    dec_i = d; k_i = kk; m_i = mm; rq[u] = 1'b1;
    @(posedge clk); #1;
    dec_i = ~d; k_i = ~kk; m_i = ~mm;
  endtask

  // Count cycles from the capture edge until ack, bounded.
  task automatic wait_ack(input int u, input string tag);
    int lat;
    lat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (ack_v[u] === 1'b1) begin lat = cyc; break; end
      if (cyc == 1) begin @(posedge clk); #1; if (ack_v[u] === 1'b1) begin lat = 1; break; end end
    end
    check({tag, " latency"}, 64'(lat), 64'(16 >> u));
  endtask

  task automatic run_op(input int u, input logic d, input logic [63:0] kk, input logic [63:0] mm,
                        input logic [63:0] exp_c, input string tag);
    start(u, d, kk, mm);
    wait_ack(u, tag);
    check({tag, " c"}, c_v[u], exp_c);
    rq[u] = 1'b0;
    @(posedge clk); #1;
    check({tag, " ack low"}, 64'(ack_v[u]), 64'd0);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 5; i++) rq[i] = 1'b0;
    dec_i = 1'b0; k_i = '0; m_i = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #10;
    check("reset ack u1", 64'(ack_v[0]), 64'd0);
    check("reset c u1", c_v[0], 64'd0);
    check("reset ack u16", 64'(ack_v[4]), 64'd0);
    check("reset c u16", c_v[4], 64'd0);
    @(negedge clk) rst = 1'b0;

    run_op(0, 1'b0, K1, P1, C1, "enc u1");
    run_op(0, 1'b1, K1, C1, P1, "dec u1");
    for (int u = 1; u < 5; u++) begin
      run_op(u, 1'b0, K2, P2, C2, $sformatf("enc u%0d", 1 << u));
      run_op(u, 1'b1, K2, C2, P2, $sformatf("dec u%0d", 1 << u));
    end

    // Abort: req dropped so the fifth RUN edge samples it low.
    start(0, 1'b0, K2, P2);
    repeat (4) begin @(posedge clk); #1; end
    rq[0] = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (ack_v[0] !== 1'b0) seen = 1'b1; end
    check("abort ack", 64'(seen), 64'd0);
    check("abort c held", c_v[0], P1);
    run_op(0, 1'b0, K1, P1, C1, "after abort");

    // Async reset between edges in the middle of a run.
    start(0, 1'b0, K2, P2);
    repeat (7) begin @(posedge clk); #1; end
    @(negedge clk) rst = 1'b1;
    #1;
    check("mid reset ack", 64'(ack_v[0]), 64'd0);
    check("mid reset c", c_v[0], 64'd0);
    rq[0] = 1'b0;
    @(negedge clk) rst = 1'b0;
    run_op(0, 1'b1, K1, C1, P1, "after reset");

    // req held high in DONE must not restart, even with new operands.
    start(0, 1'b0, K2, P2);
    wait_ack(0, "hold");
    dec_i = 1'b0; k_i = K1; m_i = P1;
    repeat (10) begin
      @(posedge clk); #1;
      check("hold ack", 64'(ack_v[0]), 64'd1);
      check("hold c", c_v[0], C2);
    end
    rq[0] = 1'b0;
    @(posedge clk); #1;
    check("release ack", 64'(ack_v[0]), 64'd0);
    check("release c", c_v[0], C2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/crypt_iter_unroll.md
# crypt_iter_unroll

Iterative DES-style block cipher core that supports both encryption and decryption. It applies a configurable number of Feistel rounds per clock cycle, from fully iterative to fully unrolled. It reuses the existing `pre_processing`, `round` and `post_processing` blocks and wraps them in a registered round datapath, a round counter and a four-phase req/ack handshake. It sits where `encrypt_iter` sits today and is the drop-in successor for systems that need decryption or a different area/latency trade-off.

## Interface
- `UNROLL`, default 1: Feistel rounds applied per clock. Legal values are 1, 2, 4, 8 and 16; any other value must fail elaboration.
- `N_R`, default `` `N_R `` (16): total rounds. It must be divisible by `UNROLL`.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req`  in  1: request. Four-phase handshake with `ack`.
- `dec`  in  1: mode, 0 = encrypt, 1 = decrypt. Sampled with `k`/`m` at request capture.
- `k`  in  `` `N_K `` (64): cipher key, parity bits ignored by PC1.
- `m`  in  `` `N_B `` (64): input block (plaintext or ciphertext).
- `c`  out  `` `N_B ``: result block, registered.
- `ack`  out  1: acknowledge, registered.

## Operation
- Datapath registers:
  - `lr` (64 b): L in bits 63:32, R in bits 31:0, loaded from `pre_processing` halves r1/r0.
  - `cd` (56 b): key schedule state, loaded from PC1 output.
  - `cnt`: round counter, width $clog2(N_R+1).
  - `mode`: latched `dec`.
- Each cycle a combinational chain of `UNROLL` `round` instances runs. Instance i uses round number j = cnt + i + 1, with j in 1..16.
- Key-state rotation per round j, applied to C and D independently (28 b each):
  - Encrypt: rotate left by 1 for j ∈ {1,2,9,16}, otherwise by 2. Rotation is applied before the subkey is used.
  - Decrypt: no rotation for j = 1; rotate right by 1 for j ∈ {2,9,16}, otherwise by 2. Rotation is applied before subkey use.
  - The rotated `cd` feeds `round` (PC2 is internal to `round`) and is passed to the next instance.
- After round 16, the output halves are swapped (R16‖L16) and passed through `post_processing` into `c`.
- FSM:
  - IDLE: `ack`=0. On `req`=1, capture `mode`, load `lr`/`cd` from `pre_processing(k,m)`, set `cnt`=0, go to RUN.
  - RUN: each edge, `lr`,`cd` ← output of the UNROLL-round chain and `cnt` += UNROLL.
    - When the new `cnt` = N_R: `c` ← `post_processing` result, `ack` ← 1, go to DONE.
    - If `req`=0 at any RUN edge: abort to IDLE. `c` is unchanged and `ack` stays 0.
  - DONE: hold `c` and `ack`=1. On `req`=0, `ack` ← 0 and go to IDLE.
- A new request is not accepted until `ack` has returned low. A `req` held high in DONE does not restart the core.
- `k`, `m` and `dec` may change freely after the capture edge.

## Timing
- Reset (async, any state): FSM → IDLE, `ack`=0, `c`=0, `cnt`=0, `lr`=0, `cd`=0, `mode`=0.
- Reset asserted mid-RUN discards the operation with no partial `c` update.
- Capture edge E0 is the first rising edge with `req`=1 in IDLE.
- `ack` and `c` become valid after edge E0 + N_R/UNROLL: 16 cycles for UNROLL=1, 1 cycle for UNROLL=16.
- `ack` falls on the first edge in DONE that samples `req`=0.
- The earliest next capture is on the following edge.
- Minimum request-to-request period is N_R/UNROLL + 2 cycles.
- Critical path grows linearly with UNROLL (UNROLL × round delay). UNROLL=16 is for low-frequency use.

## Test plan
- Encrypt, UNROLL=1: k=133457799BBCDFF1, m=0123456789ABCDEF, dec=0 → `ack` rises 16 cycles after capture, c=85E813540F0AB405.
- Decrypt, UNROLL=1: same k, m=85E813540F0AB405, dec=1 → c=0123456789ABCDEF after 16 cycles.
- Sweep UNROLL over 2, 4, 8 and 16 with k=0E329232EA6D0D73, m=8787878787878787, dec=0 → c=0000000000000000 with latency 8/4/2/1 cycles. Decrypt then recovers m.
- Abort: drop `req` at RUN cycle 5 (UNROLL=1) → `ack` never rises, c keeps its previous value, and the next full request completes correctly.
- Async reset mid-RUN (UNROLL=1, cycle 8), asserted between clock edges → `ack`=0 and c=0 immediately. After release, a fresh request gives the correct result.
- Handshake hold: keep `req`=1 for 10 cycles after `ack` → `ack` and c remain stable with no second operation. `req`=0 → `ack`=0 on the next edge.
